// File: rtl/temp_ctrl_pkg.sv
// Shared types and state encoding for the temperature sample controller.
package temp_ctrl_pkg;

    localparam int unsigned TEMP_W = 5;
    typedef logic [TEMP_W-1:0] temp_t;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] EN   = 3'd1;
    localparam logic [2:0] READ = 3'd2;
    localparam logic [2:0] EVAL = 3'd3;
    localparam logic [2:0] ERR  = 3'd4;

    typedef enum logic [2:0] {
        StIdle = IDLE,
        StEn   = EN,
        StRead = READ,
        StEval = EVAL,
        StErr  = ERR
    } state_e;

endpackage

// File: rtl/temp_sample_ctrl_if.sv
// Sensor-side handshake: the controller (master) enables/strobes, the sensor (slave) returns data.
interface temp_sample_ctrl_if;
    import temp_ctrl_pkg::*;

    temp_t temperatura;
    logic  temp_vld;
    logic  en_m1;
    logic  lect;

    modport master (output en_m1, output lect, input temperatura, input temp_vld);
    modport slave  (input en_m1, input lect, output temperatura, output temp_vld);

endinterface

// File: rtl/temp_hyst_cmp.sv
// Single registered hysteresis comparator; qual gates the on-transition, force_on overrides.
module temp_hyst_cmp
    import temp_ctrl_pkg::*;
#(
    parameter temp_t ON_TH  = 5'd25,
    parameter temp_t OFF_TH = 5'd22
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  upd,
    input  logic  qual,
    input  logic  force_on,
    input  temp_t value,
    output logic  state
);

    logic state_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= 1'b0;
        end else if (force_on) begin
            state_q <= 1'b1;
        end else if (upd) begin
            if (qual && (value >= ON_TH)) begin
                state_q <= 1'b1;
            end else if (value <= OFF_TH) begin
                state_q <= 1'b0;
            end
        end
    end

    assign state = state_q;

endmodule

// File: rtl/temp_sample_ctrl.sv
// Periodic sensor sequencer with fan/alarm hysteresis. Optional TEMP_ALARM_BLINK_EN makes
// est_alarma toggle once per sample tick while the alarm condition holds.
module temp_sample_ctrl
    import temp_ctrl_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 100000,
    parameter temp_t       FAN_ON     = 5'd25,
    parameter temp_t       FAN_OFF    = 5'd22,
    parameter temp_t       ALARM_ON   = 5'd30,
    parameter temp_t       ALARM_OFF  = 5'd28,
    parameter int unsigned ALARM_CNT  = 3,
    parameter int unsigned RD_TIMEOUT = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    temp_sample_ctrl_if.master        sens,
    output temp_t                     temp_q,
    output logic                      est_ventilador,
    output logic                      est_alarma,
    output logic                      sens_err
);

    localparam int unsigned        TIMER_W   = $clog2(SAMPLE_DIV);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(SAMPLE_DIV - 1);
    localparam logic [7:0]         RD_LAST   = 8'(RD_TIMEOUT - 1);
    localparam logic [2:0]         CNT_SAT   = 3'(ALARM_CNT);

    logic [TIMER_W-1:0] timer_q;
    logic               tick;
    state_e             state_q;
    logic [7:0]         rd_cnt_q;
    logic [2:0]         over_cnt_q;
    logic [2:0]         over_cnt_nxt;
    logic               en_m1_q;
    logic               lect_q;
    logic               eval;
    logic               in_err;
    logic               alarm_qual;
    logic               alarm_st;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else if (tick) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 1'b1;
        end
    end

    assign tick = (timer_q == TIMER_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            rd_cnt_q   <= '0;
            over_cnt_q <= '0;
            temp_q     <= '0;
            sens_err   <= 1'b0;
            en_m1_q    <= 1'b0;
            lect_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (tick) begin
                        state_q <= StEn;
                        en_m1_q <= 1'b1;
                    end
                end
                StEn: begin
                    state_q  <= StRead;
                    lect_q   <= 1'b1;
                    rd_cnt_q <= '0;
                end
                StRead: begin
                    // A valid sample on the final timeout cycle still counts.
                    if (sens.temp_vld) begin
                        temp_q  <= sens.temperatura;
                        state_q <= StEval;
                        en_m1_q <= 1'b0;
                        lect_q  <= 1'b0;
                    end else if (rd_cnt_q == RD_LAST) begin
                        state_q <= StErr;
                        en_m1_q <= 1'b0;
                        lect_q  <= 1'b0;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 8'd1;
                    end
                end
                StEval: begin
                    over_cnt_q <= over_cnt_nxt;
                    sens_err   <= 1'b0;
                    state_q    <= StIdle;
                end
                StErr: begin
                    over_cnt_q <= '0;
                    sens_err   <= 1'b1;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sens.en_m1 = en_m1_q;
    assign sens.lect  = lect_q;
    assign eval       = (state_q == StEval);
    assign in_err     = (state_q == StErr);

    always_comb begin
        over_cnt_nxt = '0;
        if (temp_q >= ALARM_ON) begin
            over_cnt_nxt = (over_cnt_q == CNT_SAT) ? over_cnt_q : over_cnt_q + 3'd1;
        end
    end

    assign alarm_qual = (over_cnt_nxt == CNT_SAT);

    temp_hyst_cmp #(
        .ON_TH  (FAN_ON),
        .OFF_TH (FAN_OFF)
    ) u_fan (
        .clock    (clock),
        .reset    (reset),
        .upd      (eval),
        .qual     (1'b1),
        .force_on (1'b0),
        .value    (temp_q),
        .state    (est_ventilador)
    );

    temp_hyst_cmp #(
        .ON_TH  (ALARM_ON),
        .OFF_TH (ALARM_OFF)
    ) u_alarm (
        .clock    (clock),
        .reset    (reset),
        .upd      (eval),
        .qual     (alarm_qual),
        .force_on (in_err),
        .value    (temp_q),
        .state    (alarm_st)
    );

`ifdef TEMP_ALARM_BLINK_EN
    logic alarm_prev_q;
    logic blink_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alarm_prev_q <= 1'b0;
            blink_q      <= 1'b0;
        end else begin
            alarm_prev_q <= alarm_st;
            if (!alarm_st) begin
                blink_q <= 1'b0;
            end else if (!alarm_prev_q) begin
                blink_q <= 1'b1;
            end else if (tick) begin
                blink_q <= ~blink_q;
            end
        end
    end

    assign est_alarma = blink_q;
`else
    assign est_alarma = alarm_st;
`endif

endmodule
